// File: rtl/jpc_ifetch_q_pkg.sv
// Shared configuration for the instruction-fetch queue: global widths plus
// fetch-unit defaults, overridable from the build via the macros below.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif
`ifndef JPC_INSTRUCTION_WIDTH
`define JPC_INSTRUCTION_WIDTH 32
`endif
`ifndef JPC_IFETCH_DEPTH
`define JPC_IFETCH_DEPTH 4
`endif
`ifndef JPC_IFETCH_PC_STEP
`define JPC_IFETCH_PC_STEP 4
`endif
`ifndef JPC_RESET_PC
`define JPC_RESET_PC 0
`endif

package jpc_ifetch_q_pkg;
    localparam int IFQ_ADDR_W   = `JPC_ADDRESS_WIDTH;
    localparam int IFQ_DATA_W   = `JPC_INSTRUCTION_WIDTH;
    localparam int IFQ_DEPTH    = `JPC_IFETCH_DEPTH;
    localparam int IFQ_PC_STEP  = `JPC_IFETCH_PC_STEP;
    localparam int IFQ_RESET_PC = `JPC_RESET_PC;
endpackage

// File: rtl/jpc_ifetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries; flush empties it in one
// cycle and the occupancy is exported for the credit logic.
module jpc_ifetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_push = push && (count != CW'(DEPTH) || pop);
    assign do_pop  = pop && count != '0;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/jpc_ifetch_q.sv
// Prefetching instruction-fetch unit: credit-limited address issue, in-order
// response capture with PC tagging, and redirect flush with stale-drop count.
module jpc_ifetch_q
    import jpc_ifetch_q_pkg::*;
#(
    parameter int                ADDR_W   = IFQ_ADDR_W,
    parameter int                DATA_W   = IFQ_DATA_W,
    parameter int                DEPTH    = IFQ_DEPTH,
    parameter int                PC_STEP  = IFQ_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid_I,
    input  logic [ADDR_W-1:0] redirect_pc_I,
    output logic [ADDR_W-1:0] mem_addr_O,
    output logic              mem_addr_valid_O,
    input  logic              mem_addr_ready_I,
    input  logic [DATA_W-1:0] mem_data_I,
    input  logic              mem_data_valid_I,
    output logic              mem_data_ready_O,
    output logic [DATA_W-1:0] instr_O,
    output logic [ADDR_W-1:0] instr_pc_O,
    output logic              instr_valid_O,
    input  logic              instr_ready_I,
    output logic              busy_O
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]     out_cnt, drop_cnt, q_cnt;
    logic [CW-1:0]     out_nxt, drop_nxt, q_nxt;
    logic [CW:0]       credit_used;
    logic              addr_vld, addr_vld_nxt, data_rdy;
    logic              addr_hs, data_hs, instr_hs, push, flush;
    logic [EW-1:0]     head;

    assign addr_hs  = addr_vld && mem_addr_ready_I;
    assign data_hs  = mem_data_valid_I && data_rdy;
    assign instr_hs = instr_valid_O && instr_ready_I;
    assign flush    = redirect_valid_I;
    // Any response arriving in a redirect cycle belongs to the old stream.
    assign push     = data_hs && !flush && drop_cnt == '0;

    always_comb begin
        out_nxt = out_cnt + CW'(addr_hs) - CW'(data_hs);
        q_nxt   = flush ? '0 : q_cnt + CW'(push) - CW'(instr_hs);
        drop_nxt = drop_cnt;
        if (flush)
            drop_nxt = out_nxt;
        else if (data_hs && drop_cnt != '0)
            drop_nxt = drop_cnt - 1'b1;
        // Valid is registered, so credit is judged on post-edge occupancy.
        credit_used  = {1'b0, q_nxt} + {1'b0, out_nxt};
        addr_vld_nxt = !flush && credit_used < (CW+1)'(DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            addr_vld <= 1'b0;
            data_rdy <= 1'b0;
        end else begin
            if (flush) begin
                fetch_pc <= redirect_pc_I;
                resp_pc  <= redirect_pc_I;
            end else begin
                if (addr_hs) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                if (push)    resp_pc  <= resp_pc + ADDR_W'(PC_STEP);
            end
            out_cnt  <= out_nxt;
            drop_cnt <= drop_nxt;
            addr_vld <= addr_vld_nxt;
            data_rdy <= 1'b1;
        end
    end

    jpc_ifetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({resp_pc, mem_data_I}),
        .pop       (instr_hs),
        .flush     (flush),
        .head      (head),
        .count     (q_cnt)
    );

    assign mem_addr_O       = fetch_pc;
    assign mem_addr_valid_O = addr_vld;
    assign mem_data_ready_O = data_rdy;
    assign instr_valid_O    = q_cnt != '0;
    assign instr_O          = head[DATA_W-1:0];
    assign instr_pc_O       = head[EW-1:DATA_W];
    assign busy_O           = out_cnt != '0 || drop_cnt != '0;
endmodule

// File: tb/tb_jpc_ifetch_q.sv
// Randomized bench: an in-order memory model plus a stream-level reference
// (issued and delivered PCs restart at each redirect and step by 4).
module tb_jpc_ifetch_q;
    localparam int AW = 32, DW = 32, DEPTH = 4, STEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid_I;
    logic [AW-1:0] redirect_pc_I;
    logic [AW-1:0] mem_addr_O;
    logic          mem_addr_valid_O;
    logic          mem_addr_ready_I;
    logic [DW-1:0] mem_data_I;
    logic          mem_data_valid_I;
    logic          mem_data_ready_O;
    logic [DW-1:0] instr_O;
    logic [AW-1:0] instr_pc_O;
    logic          instr_valid_O;
    logic          instr_ready_I;
    logic          busy_O;

    always #5 clk = ~clk;

    jpc_ifetch_q #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .PC_STEP(STEP), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid_I(redirect_valid_I), .redirect_pc_I(redirect_pc_I),
        .mem_addr_O(mem_addr_O), .mem_addr_valid_O(mem_addr_valid_O), .mem_addr_ready_I(mem_addr_ready_I),
        .mem_data_I(mem_data_I), .mem_data_valid_I(mem_data_valid_I), .mem_data_ready_O(mem_data_ready_O),
        .instr_O(instr_O), .instr_pc_O(instr_pc_O), .instr_valid_O(instr_valid_O),
        .instr_ready_I(instr_ready_I), .busy_O(busy_O)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t        mq[$];
    int          cyc, total, bad, lat;
    logic [31:0] exp_fetch, exp_pc;
    logic        s_ah, s_dh, s_ih, s_iv;
    int          s_cyc;
    logic [31:0] s_ipc, s_addr;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234ABCD;
    endfunction

    // One clock: present memory response, score handshakes, advance models.
    task automatic step();
        int due;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_data_valid_I = 1'b1;
            mem_data_I = mword(mq[0].addr);
        end else begin
            mem_data_valid_I = 1'b0;
            mem_data_I = '0;
        end
        #1;
        s_cyc  = cyc;
        s_ah   = mem_addr_valid_O && mem_addr_ready_I;
        s_dh   = mem_data_valid_I && mem_data_ready_O;
        s_ih   = instr_valid_O && instr_ready_I;
        s_iv   = instr_valid_O;
        s_ipc  = instr_pc_O;
        s_addr = mem_addr_O;
        if (s_ah) begin
            total++;
            if (mem_addr_O !== exp_fetch) begin
                bad++;
                $display("FAIL addr_seq cyc=%0d got=%h want=%h", cyc, mem_addr_O, exp_fetch);
            end
        end
        if (s_ih) begin
            total++;
            if (instr_pc_O !== exp_pc || instr_O !== mword(exp_pc)) begin
                bad++;
                $display("FAIL instr_seq cyc=%0d got pc=%h w=%h want pc=%h w=%h",
                         cyc, instr_pc_O, instr_O, exp_pc, mword(exp_pc));
            end
        end
        if (s_dh) void'(mq.pop_front());
        if (s_ah) begin
            due = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
            mq.push_back('{addr: mem_addr_O, due: due});
        end
        if (redirect_valid_I) begin
            exp_fetch = redirect_pc_I;
            exp_pc    = redirect_pc_I;
        end else begin
            if (s_ah) exp_fetch = exp_fetch + 32'(STEP);
            if (s_ih) exp_pc    = exp_pc + 32'(STEP);
        end
        total++;
        if (mq.size() > DEPTH) begin
            bad++;
            $display("FAIL credit cyc=%0d outstanding=%0d max=%0d", cyc, mq.size(), DEPTH);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid_I = 1'b1;
        redirect_pc_I = pc;
        step();
        redirect_valid_I = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (mem_addr_valid_O !== 1'b0 || mem_data_ready_O !== 1'b0 || instr_valid_O !== 1'b0 ||
            busy_O !== 1'b0 || mem_addr_O !== 32'h0 || instr_O !== 32'h0 || instr_pc_O !== 32'h0) begin
            bad++;
            $display("FAIL %s got av=%b dr=%b iv=%b busy=%b addr=%h instr=%h pc=%h want all zero",
                     tag, mem_addr_valid_O, mem_data_ready_O, instr_valid_O, busy_O, mem_addr_O, instr_O, instr_pc_O);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid_I = 0; redirect_pc_I = 0; mem_addr_ready_I = 0;
        mem_data_valid_I = 0; mem_data_I = 0; instr_ready_I = 0;
        lat = 1; cyc = 0; exp_fetch = 0; exp_pc = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        step();
        total++;
        if (mem_data_ready_O !== 1'b1 || mem_addr_valid_O !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready got dr=%b av=%b want 1 1", mem_data_ready_O, mem_addr_valid_O);
        end
    endtask

    task automatic test_stream();
        int a = -1, v = -1, n = 0;
        logic [31:0] pcs[$];
        lat = 1; mem_addr_ready_I = 1; instr_ready_I = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_ah && a < 0) a = s_cyc;
            if (s_iv && v < 0) v = s_cyc;
            if (s_ih) pcs.push_back(s_ipc);
        end
        total++;
        if (v != a + 2 || a < 0) begin
            bad++; $display("FAIL first_valid_latency got=%0d want=%0d", v, a + 2);
        end
        total++;
        if (pcs.size() < 3 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8) begin
            bad++; $display("FAIL first_pcs got n=%0d want 0,4,8", pcs.size());
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_ih) n++;
        end
        total++;
        if (n != 20) begin bad++; $display("FAIL throughput got=%0d want=20", n); end
    endtask

    task automatic test_full();
        int n = 0;
        lat = 2; instr_ready_I = 0; mem_addr_ready_I = 1;
        redirect_to(32'h200);
        for (int i = 0; i < 20; i++) begin step(); if (s_ah) n++; end
        total++;
        if (n != DEPTH) begin bad++; $display("FAIL full_issue_count got=%0d want=%0d", n, DEPTH); end
        total++;
        if (mem_addr_valid_O !== 1'b0 || instr_valid_O !== 1'b1 || instr_pc_O !== 32'h200) begin
            bad++;
            $display("FAIL full_state got av=%b iv=%b pc=%h want 0 1 200", mem_addr_valid_O, instr_valid_O, instr_pc_O);
        end
        instr_ready_I = 1; step(); instr_ready_I = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin step(); if (s_ah) n++; end
        total++;
        if (n != 1) begin bad++; $display("FAIL pop_refill got=%0d want=1", n); end
    endtask

    // Redirect while memory still owes responses, then watch them drain.
    task automatic drain_after_redirect(input string tag);
        int i;
        for (i = 0; i < 12 && mq.size() > 0; i++) begin
            total++;
            if (busy_O !== 1'b1 || instr_valid_O !== 1'b0) begin
                bad++; $display("FAIL %s_drain got busy=%b iv=%b want 1 0", tag, busy_O, instr_valid_O);
            end
            step();
        end
        total++;
        if (mq.size() != 0 || busy_O !== 1'b0 || instr_valid_O !== 1'b0) begin
            bad++; $display("FAIL %s_idle got busy=%b iv=%b left=%0d want 0 0 0", tag, busy_O, instr_valid_O, mq.size());
        end
    endtask

    task automatic test_redirect_drop();
        int i;
        logic [31:0] first_pc;
        lat = 3; instr_ready_I = 1; mem_addr_ready_I = 1;
        redirect_to(32'h80);
        for (i = 0; i < 30 && mq.size() != 3; i++) step();
        total++;
        if (mq.size() != 3) begin bad++; $display("FAIL three_inflight got=%0d want=3", mq.size()); end
        mem_addr_ready_I = 0;
        redirect_to(32'h100);
        drain_after_redirect("stale3");
        mem_addr_ready_I = 1;
        first_pc = 32'hDEAD_BEEF;
        for (i = 0; i < 20; i++) begin
            step();
            if (s_ih) begin first_pc = s_ipc; break; end
        end
        total++;
        if (first_pc !== 32'h100) begin bad++; $display("FAIL first_after_redirect got=%h want=100", first_pc); end
    endtask

    task automatic test_same_cycle();
        lat = 1; instr_ready_I = 1; mem_addr_ready_I = 1;
        repeat (6) step();
        redirect_to(32'h400);
        total++;
        if (!(s_ah && s_dh)) begin bad++; $display("FAIL same_cycle_hs got ah=%b dh=%b want 1 1", s_ah, s_dh); end
        mem_addr_ready_I = 0;
        drain_after_redirect("same_cycle");
        mem_addr_ready_I = 1;
        repeat (8) step();
    endtask

    task automatic test_stall();
        logic [31:0] held;
        lat = 1; instr_ready_I = 1; mem_addr_ready_I = 1;
        repeat (4) step();
        mem_addr_ready_I = 0;
        held = mem_addr_O;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (mem_addr_valid_O !== 1'b1 || mem_addr_O !== held) begin
                bad++; $display("FAIL stall_hold got av=%b addr=%h want 1 %h", mem_addr_valid_O, mem_addr_O, held);
            end
        end
        mem_addr_ready_I = 1;
        step();
        total++;
        if (!s_ah || s_addr !== held || mem_addr_O !== held + 32'(STEP)) begin
            bad++; $display("FAIL stall_release got ah=%b addr=%h want 1 %h", s_ah, mem_addr_O, held + 32'(STEP));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seen[$];
        lat = 1; instr_ready_I = 1; mem_addr_ready_I = 1;
        redirect_to(32'hFFFF_FFF8);
        for (int i = 0; i < 12; i++) begin step(); if (s_ah) seen.push_back(s_addr); end
        total++;
        if (seen.size() < 3 || seen[0] !== 32'hFFFF_FFF8 || seen[1] !== 32'hFFFF_FFFC || seen[2] !== 32'h0) begin
            bad++; $display("FAIL pc_wrap got n=%0d want FFFFFFF8,FFFFFFFC,00000000", seen.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 4);
            instr_ready_I = ($urandom_range(0, 9) < 7);
            mem_addr_ready_I = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) == 0) redirect_to($urandom & 32'hFFFF_FFFC);
            else step();
        end
        instr_ready_I = 1; mem_addr_ready_I = 1;
        repeat (10) step();
    endtask

    task automatic test_async_reset();
        lat = 1; instr_ready_I = 1; mem_addr_ready_I = 1;
        redirect_to(32'h5000);
        repeat (6) step();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        mem_data_valid_I = 0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); exp_fetch = 0; exp_pc = 0;
        repeat (12) step();
        total++;
        if (exp_pc == 32'h0) begin bad++; $display("FAIL restart_progress got pc=%h want nonzero", exp_pc); end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_same_cycle();
        test_stall();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
